// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one combinational ALU between two
//               valid/ready requesters. The winner's operands are captured,
//               driven to the ALU for one cycle, and the registered result and
//               flags are held until the owning requester accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,

    // Requester 0 operation channel
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,

    // Requester 1 operation channel
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,

    // Response channels (result/flags shared, valid per requester)
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,

    // Shared combinational ALU
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_negative,
    input  logic             alu_carry,

    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_owner;        // requester owning the current operation
    logic               r_last_grant;   // most recent winner, for round-robin
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [SEL_W-1:0]   r_alu_sel;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;

    logic               w_grant0;
    logic               w_grant1;
    logic               w_grant_any;
    logic               w_rsp_take;
    logic               w_exec_done;

    // Next-state and arbitration decode; grants exist only while idle
    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_rsp_take  = 1'b0;
        w_exec_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Requester 0 wins unless requester 1 also asks and 0 went last
                w_grant0 = req0_valid && (!req1_valid || r_last_grant);
                w_grant1 = req1_valid && !w_grant0;
                if (w_grant0 || w_grant1) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_exec_done = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                // Only the owner's ready retires the response
                w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;
                if (w_rsp_take) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_grant_any = w_grant0 || w_grant1;

    // State register; reset abandons any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ownership and round-robin pointer, updated only on a grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_grant_any) begin
            r_owner      <= w_grant1;
            r_last_grant <= w_grant1;
        end
    end

    // Operand capture from the winning requester; held in every other cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
        end else if (w_grant0) begin
            r_alu_a   <= req0_a;
            r_alu_b   <= req0_b;
            r_alu_sel <= req0_sel;
        end else if (w_grant1) begin
            r_alu_a   <= req1_a;
            r_alu_b   <= req1_b;
            r_alu_sel <= req1_sel;
        end
    end

    // Result and flag capture at the end of the single execute cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_flags  <= 4'b0000;
        end else if (w_exec_done) begin
            r_result <= alu_out;
            r_flags  <= {alu_zero, alu_overflow, alu_negative, alu_carry};
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Response valids decode straight from state so reset clears them at once
    assign rsp0_valid = (r_state == S_RESP) && !r_owner;
    assign rsp1_valid = (r_state == S_RESP) &&  r_owner;

    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;

    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_sel = r_alu_sel;

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a transaction-level
//               reference model, a behavioural ALU and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_sel, req1_sel;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_sel;
    logic        alu_zero, alu_overflow, alu_negative, alu_carry;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    alu_arbiter #(.WIDTH(32), .SEL_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_negative(alu_negative), .alu_carry(alu_carry),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {zero, overflow, negative, carry, result}
    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] sel);
        logic [31:0] r;
        logic        c, o;
        r = 32'd0; c = 1'b0; o = 1'b0;
        case (sel)
            3'd0: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                r = a - b;
                c = (a < b);
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), o, r[31], c, r};
    endfunction

    always_comb {alu_zero, alu_overflow, alu_negative, alu_carry, alu_out} = alu_f(alu_a, alu_b, alu_sel);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: protocol phase (0 idle, 1 executing, 2 result pending)
    int          m_phase = 0;
    logic        m_last  = 1'b1;
    logic        m_owner = 1'b0;
    logic [31:0] m_a = 0, m_b = 0, m_res = 0;
    logic [2:0]  m_sel = 0;
    logic [3:0]  m_flg = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_last <= 1'b1; m_owner <= 1'b0;
            m_a <= 0; m_b <= 0; m_sel <= 0; m_res <= 0; m_flg <= 0;
        end else begin
            case (m_phase)
                0: if (req0_valid && (!req1_valid || m_last)) begin
                       m_a <= req0_a; m_b <= req0_b; m_sel <= req0_sel;
                       m_owner <= 1'b0; m_last <= 1'b0; m_phase <= 1;
                   end else if (req1_valid) begin
                       m_a <= req1_a; m_b <= req1_b; m_sel <= req1_sel;
                       m_owner <= 1'b1; m_last <= 1'b1; m_phase <= 1;
                   end
                1: begin
                       {m_flg, m_res} <= alu_f(m_a, m_b, m_sel);
                       m_phase <= 2;
                   end
                default: if (m_owner ? rsp1_ready : rsp0_ready) m_phase <= 0;
            endcase
        end
    end

    // Observation logs built from the DUT ports
    int          gq[$];   // granted requester per accept
    int          gc[$];   // cycle of each accept
    logic [36:0] obs[$];  // {owner, flags, result} per completed response
    int          oc[$];   // cycle of each response handshake

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic e0, e1;
        e0 = (m_phase == 0) && req0_valid && (!req1_valid || m_last);
        e1 = (m_phase == 0) && req1_valid && !e0;
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("rsp0_valid", rsp0_valid, (m_phase == 2) && !m_owner);
        chk("rsp1_valid", rsp1_valid, (m_phase == 2) && m_owner);
        chk("busy", busy, m_phase != 0);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_sel", alu_sel, m_sel);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_flags", rsp_flags, m_flg);
        if (req0_ready) begin gq.push_back(0); gc.push_back(cyc); end
        if (req1_ready) begin gq.push_back(1); gc.push_back(cyc); end
        if (rsp0_valid && rsp0_ready) begin obs.push_back({1'b0, rsp_flags, rsp_result}); oc.push_back(cyc); end
        if (rsp1_valid && rsp1_ready) begin obs.push_back({1'b1, rsp_flags, rsp_result}); oc.push_back(cyc); end
    end

    // Hold valid until the requested number of accepts has been seen
    task automatic run_ops(input int n0, input int n1);
        int  k;
        logic g0, g1;
        k = 0;
        req0_valid = (n0 > 0);
        req1_valid = (n1 > 0);
        while ((n0 > 0 || n1 > 0) && k < 60) begin
            @(negedge clk);
            g0 = req0_ready; g1 = req1_ready;
            @(posedge clk); #2;
            if (g0 && n0 > 0) begin n0--; if (n0 == 0) req0_valid = 1'b0; end
            if (g1 && n1 > 0) begin n1--; if (n1 == 0) req1_valid = 1'b0; end
            k++;
        end
        if (k >= 60) begin
            n_chk++; n_err++;
            $display("FAIL run_ops_timeout pending0=%0d pending1=%0d required=0", n0, n1);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (busy && k < 40) begin @(posedge clk); #2; k++; end
        chk("drain_busy", busy, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2; rst = 1'b1;
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;
        gq.delete(); gc.delete(); obs.delete(); oc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_busy", busy, 1'b0);
        chk("reset_result", rsp_result, 32'd0);
        chk("reset_flags", rsp_flags, 4'b0000);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_sel", alu_sel, 3'd0);
        chk("reset_rsp0_valid", rsp0_valid, 1'b0);
        rst = 1'b0;

        // Single request: 5 + 7
        req0_a = 32'd5; req0_b = 32'd7; req0_sel = 3'd0;
        rsp0_ready = 1; rsp1_ready = 1;
        run_ops(1, 0);
        drain();
        chk("single_count", obs.size(), 1);
        if (obs.size() >= 1) chk("single_rsp", obs[0], {1'b0, 4'b0000, 32'd12});
        if (gc.size() >= 1 && oc.size() >= 1) chk("single_latency", oc[0] - gc[0], 2);

        // Tie after reset: 1+1 for requester 0, 3-3 for requester 1
        do_reset();
        req0_a = 32'd1; req0_b = 32'd1; req0_sel = 3'd0;
        req1_a = 32'd3; req1_b = 32'd3; req1_sel = 3'd1;
        run_ops(1, 1);
        drain();
        chk("tie_count", obs.size(), 2);
        if (obs.size() >= 2) begin
            chk("tie_first", obs[0], {1'b0, 4'b0000, 32'd2});
            chk("tie_second", obs[1], {1'b1, 4'b1000, 32'd0});
        end

        // Backpressure on requester 1 with requester 0 waiting
        rsp1_ready = 0;
        req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_sel = 3'd0;
        run_ops(0, 1);
        req0_a = 32'd9; req0_b = 32'd4; req0_sel = 3'd1;
        req0_valid = 1;
        k = 0;
        while (!rsp1_valid && k < 10) begin @(posedge clk); #2; k++; end
        chk("bp_rsp1_valid_seen", rsp1_valid, 1'b1);
        repeat (5) begin
            @(posedge clk); #2;
            chk("bp_hold_result", rsp_result, 32'h8000_0000);
            chk("bp_hold_flags", rsp_flags, 4'b0110);
            chk("bp_req0_blocked", req0_ready, 1'b0);
        end
        gq.delete(); gc.delete(); obs.delete(); oc.delete();
        rsp1_ready = 1;
        run_ops(1, 0);
        drain();
        chk("bp_count", obs.size(), 2);
        if (obs.size() >= 2) begin
            chk("bp_first", obs[0], {1'b1, 4'b0110, 32'h8000_0000});
            chk("bp_second", obs[1], {1'b0, 4'b0000, 32'd5});
        end
        if (gc.size() >= 1 && oc.size() >= 1) chk("bp_grant_after_release", gc[0] - oc[0], 1);

        // Fairness: both continuously valid for six operations
        do_reset();
        req0_a = 32'd10; req0_b = 32'd3; req0_sel = 3'd1;
        req1_a = 32'd6;  req1_b = 32'd3; req1_sel = 3'd2;
        run_ops(3, 3);
        drain();
        chk("fair_count", gq.size(), 6);
        if (gq.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("fair_order", gq[i], i % 2);
            for (int i = 1; i < 6; i++) chk("fair_spacing", gc[i] - gc[i-1], 3);
        end
        if (obs.size() >= 2) begin
            chk("fair_res0", obs[0], {1'b0, 4'b0000, 32'd7});
            chk("fair_res1", obs[1], {1'b1, 4'b0000, 32'd2});
        end

        // Reset during execute, then during a pending response
        do_reset();
        req0_a = 32'd2; req0_b = 32'd3; req0_sel = 3'd0;
        run_ops(1, 0);
        chk("mid_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_rsp0_valid", rsp0_valid, 1'b0);
        chk("mid_rsp1_valid", rsp1_valid, 1'b0);
        @(posedge clk); #2; rst = 1'b0;
        rsp0_ready = 0;
        run_ops(1, 0);
        @(posedge clk); #2;
        chk("resp_pending", rsp0_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("resp_rst_valid", rsp0_valid, 1'b0);
        chk("resp_rst_busy", busy, 1'b0);
        @(posedge clk); #2; rst = 1'b0;
        rsp0_ready = 1;
        gq.delete(); gc.delete(); obs.delete(); oc.delete();
        req1_a = 32'd8; req1_b = 32'd8; req1_sel = 3'd4;
        run_ops(1, 1);
        drain();
        chk("post_rst_count", obs.size(), 2);
        if (gq.size() >= 1) chk("post_rst_first_grant", gq[0], 0);
        if (obs.size() >= 2) chk("post_rst_xor", obs[1], {1'b1, 4'b1000, 32'd0});

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
